// File: rtl/conv_par_mac.sv
// conv_par_mac: 1-D valid-mode convolution, P multipliers per cycle, stream in/out.
// Optional ReLU on the output register when CONV_PAR_MAC_RELU_EN is defined.
module conv_par_mac #(
  parameter int unsigned DATA_WIDTH_X = 8,
  parameter int unsigned DATA_WIDTH_F = 8,
  parameter int unsigned X_SIZE       = 128,
  parameter int unsigned F_SIZE       = 32,
  parameter int unsigned P            = 4,
  parameter int unsigned ACC_SIZE     = DATA_WIDTH_X + DATA_WIDTH_F + $clog2(F_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid_x,
  output logic                           s_ready_x,
  input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
  input  logic                           s_valid_f,
  output logic                           s_ready_f,
  input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
  output logic                           m_valid_y,
  input  logic                           m_ready_y,
  output logic signed [ACC_SIZE-1:0]     m_data_out_y
);

  localparam int unsigned PW    = DATA_WIDTH_X + DATA_WIDTH_F;
  localparam int unsigned XAW   = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned FAW   = (F_SIZE > 1) ? $clog2(F_SIZE) : 1;
  localparam int unsigned XCW   = $clog2(X_SIZE + 1);
  localparam int unsigned FCW   = $clog2(F_SIZE + 1);
  localparam int unsigned NLAST = X_SIZE - F_SIZE;
  localparam int unsigned KLAST = F_SIZE - P;

  if ((F_SIZE % P) != 0) begin : g_p_check
    $error("conv_par_mac: F_SIZE must be a multiple of P");
  end

  typedef enum logic [1:0] {LOAD, MAC, OUT} state_e;

  state_e                      state_q, state_d;
  logic [XCW-1:0]              x_cnt_q, x_cnt_d;
  logic [FCW-1:0]              f_cnt_q, f_cnt_d;
  logic [XCW-1:0]              n_q, n_d;
  logic [FCW-1:0]              k_q, k_d;
  logic signed [ACC_SIZE-1:0]  acc_q, acc_d;
  logic signed [ACC_SIZE-1:0]  y_q, y_d;
  logic signed [ACC_SIZE-1:0]  mac_sum;
  logic                        rdy_x_q, rdy_x_d;
  logic                        rdy_f_q, rdy_f_d;
  logic                        vld_q, vld_d;
  logic                        x_we, f_we;

  logic signed [DATA_WIDTH_X-1:0] x_mem [X_SIZE];
  logic signed [DATA_WIDTH_F-1:0] f_mem [F_SIZE];

  function automatic logic signed [PW-1:0] mul(input logic signed [DATA_WIDTH_X-1:0] a,
                                               input logic signed [DATA_WIDTH_F-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  assign x_we = (state_q == LOAD) && s_valid_x && rdy_x_q;
  assign f_we = (state_q == LOAD) && s_valid_f && rdy_f_q;

  // Sample memories: overwritten each frame, never cleared.
  always_ff @(posedge clk) begin
    if (x_we) x_mem[XAW'(x_cnt_q)] <= s_data_in_x;
    if (f_we) f_mem[FAW'(f_cnt_q)] <= s_data_in_f;
  end

  // P-wide partial sum for the current (n, k) slice added onto the accumulator.
  always_comb begin
    mac_sum = acc_q;
    for (int unsigned j = 0; j < P; j++) begin
      mac_sum = mac_sum + ACC_SIZE'(mul(x_mem[XAW'(n_q) + XAW'(k_q) + XAW'(j)],
                                        f_mem[FAW'(k_q) + FAW'(j)]));
    end
  end

  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    n_d     = n_q;
    k_d     = k_q;
    acc_d   = acc_q;
    y_d     = y_q;
    vld_d   = vld_q;
    rdy_x_d = 1'b0;
    rdy_f_d = 1'b0;
    unique case (state_q)
      LOAD: begin
        x_cnt_d = x_cnt_q + XCW'(x_we);
        f_cnt_d = f_cnt_q + FCW'(f_we);
        if ((x_cnt_d == XCW'(X_SIZE)) && (f_cnt_d == FCW'(F_SIZE))) begin
          state_d = MAC;
          n_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end else begin
          rdy_x_d = (x_cnt_d < XCW'(X_SIZE));
          rdy_f_d = (f_cnt_d < FCW'(F_SIZE));
        end
      end
      MAC: begin
        acc_d = mac_sum;
        if (k_q == FCW'(KLAST)) begin
`ifdef CONV_PAR_MAC_RELU_EN
          y_d = mac_sum[ACC_SIZE-1] ? '0 : mac_sum;
`else
          y_d = mac_sum;
`endif
          vld_d   = 1'b1;
          state_d = OUT;
        end else begin
          k_d = k_q + FCW'(P);
        end
      end
      OUT: begin
        if (vld_q && m_ready_y) begin
          vld_d = 1'b0;
          if (n_q < XCW'(NLAST)) begin
            n_d     = n_q + XCW'(1);
            k_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            x_cnt_d = '0;
            f_cnt_d = '0;
            rdy_x_d = 1'b1;
            rdy_f_d = 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      n_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      rdy_x_q <= 1'b1;
      rdy_f_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
      n_q     <= n_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      rdy_x_q <= rdy_x_d;
      rdy_f_q <= rdy_f_d;
    end
  end

  assign s_ready_x    = rdy_x_q;
  assign s_ready_f    = rdy_f_q;
  assign m_valid_y    = vld_q;
  assign m_data_out_y = y_q;

endmodule

// File: tb/tb_conv_par_mac.sv
// Bench for conv_par_mac at default parameters: directed frames plus random data/backpressure
// checked against a plain-arithmetic convolution model (ReLU honoured if CONV_PAR_MAC_RELU_EN).
module tb_conv_par_mac;

  localparam int XS  = 128;
  localparam int FS  = 32;
  localparam int PP  = 4;
  localparam int ACC = 21;
  localparam int NY  = XS - FS + 1;
  localparam int LAT = FS / PP;

  logic                  clk;
  logic                  reset;
  logic                  s_valid_x, s_ready_x;
  logic signed [7:0]     s_data_in_x;
  logic                  s_valid_f, s_ready_f;
  logic signed [7:0]     s_data_in_f;
  logic                  m_valid_y, m_ready_y;
  logic signed [ACC-1:0] m_data_out_y;

  int tests = 0;
  int fails = 0;
  int xv [XS];
  int fv [FS];
  int yv [NY];
  int lat, last_hs;

  conv_par_mac dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .s_data_in_x  (s_data_in_x),
    .s_valid_f    (s_valid_f),
    .s_ready_f    (s_ready_f),
    .s_data_in_f  (s_data_in_f),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y),
    .m_data_out_y (m_data_out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: Y[n] = sum_k X[n+k]*F[k], optional ReLU on the reported value.
  task automatic model();
    for (int n = 0; n < NY; n++) begin
      int s = 0;
      for (int k = 0; k < FS; k++) s += xv[n + k] * fv[k];
`ifdef CONV_PAR_MAC_RELU_EN
      if (s < 0) s = 0;
`endif
      yv[n] = s;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < XS; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < FS; k++) fv[k] = int'($urandom_range(0, 255)) - 128;
    model();
  endtask

  // Loads one frame. f_first: F streamed alone first, then X with gaps while extra F beats are offered.
  task automatic load_frame(input int gap_pct, input bit f_first);
    int xi = 0;
    int fi = 0;
    int cyc = 0;
    while ((xi < XS || fi < FS) && cyc < 5000) begin
      bit ox, of;
      ox = (xi < XS) && (!f_first || fi == FS) && (int'($urandom_range(0, 99)) >= gap_pct);
      of = (fi < FS) && (f_first || int'($urandom_range(0, 99)) >= gap_pct);
      s_valid_x   = ox;
      s_data_in_x = ox ? 8'(xv[xi]) : 8'($urandom);
      if (f_first && fi == FS) begin
        s_valid_f   = 1'b1;
        s_data_in_f = 8'($urandom);
        chk("f_extra_beat_ready", s_ready_f, 0);
      end else begin
        s_valid_f   = of;
        s_data_in_f = of ? 8'(fv[fi]) : 8'($urandom);
      end
      if (f_first && ox) chk("x_ready_during_load", s_ready_x, 1);
      if (ox && s_ready_x === 1'b1) xi++;
      if (of && s_ready_f === 1'b1) fi++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    chk("load_done_in_budget", (cyc < 5000), 1);
    chk("ready_x_low_after_full", s_ready_x, 0);
    chk("ready_f_low_after_full", s_ready_f, 0);
    chk("no_y_at_mac_entry", m_valid_y, 0);
  endtask

  // Drains n_exp results with m_ready_y high rdy_pct% of cycles; checks data, hold and count.
  task automatic collect(input int n_exp, input int rdy_pct, output int first_lat, output int last_cyc);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic signed [ACC-1:0] prev = '0;
    first_lat = -1;
    last_cyc  = -1;
    while (got < n_exp && cyc < 20000) begin
      bit r;
      r = (int'($urandom_range(0, 99)) < rdy_pct);
      if (stalled) begin
        chk("y_valid_held", m_valid_y, 1);
        chk("y_data_held", m_data_out_y, prev);
      end
      if (m_valid_y === 1'b1 && first_lat < 0) first_lat = cyc;
      m_ready_y = r;
      if (m_valid_y === 1'b1 && r) begin
        chk($sformatf("y[%0d]", got), m_data_out_y, yv[got]);
        got++;
        last_cyc = cyc;
      end
      stalled = (m_valid_y === 1'b1) && !r;
      prev    = m_data_out_y;
      @(posedge clk); #1;
      cyc++;
    end
    m_ready_y = 1'b0;
    chk("y_handshake_count", got, n_exp);
  endtask

  task automatic frame_end_checks();
    chk("ready_x_after_frame", s_ready_x, 1);
    chk("ready_f_after_frame", s_ready_f, 1);
    chk("no_extra_y_after_frame", m_valid_y, 0);
  endtask

  initial begin
    reset = 1'b1;
    s_valid_x = 1'b0; s_data_in_x = '0;
    s_valid_f = 1'b0; s_data_in_f = '0;
    m_ready_y = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready_x", s_ready_x, 1);
    chk("rst_ready_f", s_ready_f, 1);
    chk("rst_valid_y", m_valid_y, 0);
    chk("rst_data_y", m_data_out_y, 0);

    // All ones: every Y is 32, fixed latency and throughput.
    for (int i = 0; i < XS; i++) xv[i] = 1;
    for (int k = 0; k < FS; k++) fv[k] = 1;
    model();
    load_frame(0, 1'b0);
    collect(NY, 100, lat, last_hs);
    chk("first_y_latency", lat, LAT);
    chk("last_y_cycle", last_hs, LAT + (NY - 1) * (LAT + 1));
    frame_end_checks();

    // Ramp with single negative tap: descending outputs crossing zero.
    for (int i = 0; i < XS; i++) xv[i] = i - 64;
    for (int k = 0; k < FS; k++) fv[k] = (k == 0) ? -1 : 0;
    model();
    load_frame(0, 1'b0);
    collect(NY, 100, lat, last_hs);
    frame_end_checks();

    // Extremes: largest magnitude sum must not wrap.
    for (int i = 0; i < XS; i++) xv[i] = -128;
    for (int k = 0; k < FS; k++) fv[k] = -128;
    model();
    load_frame(10, 1'b0);
    collect(NY, 100, lat, last_hs);
    frame_end_checks();

    // Random data with random backpressure.
    rand_data();
    load_frame(25, 1'b0);
    collect(NY, 50, lat, last_hs);
    frame_end_checks();

    // F first, X with gaps and extra F beats offered while F is full.
    rand_data();
    load_frame(40, 1'b1);
    collect(NY, 70, lat, last_hs);
    frame_end_checks();

    // Reset inside MAC after 10 results, then a clean frame.
    rand_data();
    load_frame(0, 1'b0);
    collect(10, 100, lat, last_hs);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_valid_y", m_valid_y, 0);
    chk("midrst_data_y", m_data_out_y, 0);
    chk("midrst_ready_x", s_ready_x, 1);
    chk("midrst_ready_f", s_ready_f, 1);
    rand_data();
    load_frame(20, 1'b0);
    collect(NY, 100, lat, last_hs);
    chk("post_rst_first_latency", lat, LAT);
    frame_end_checks();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
